// File: rtl/mole_judge_pkg.sv
// Shared constants for the whack-a-mole judge: FSM encoding, mole count,
// LFSR polynomial and the default 50 MHz tick counts.
package mole_judge_pkg;

  localparam int NUM_MOLES = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;

  // Right-shift Galois mask for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_MOLE_TICKS     = 50_000_000;
  localparam int DEF_GAP_TICKS      = 12_500_000;
  localparam int DEF_DEBOUNCE_TICKS = 500_000;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/mole_judge_key_debounce.sv
// One pushbutton: 2-FF synchroniser, hold-time debouncer and a one-cycle
// press pulse on each accepted release->press transition.
module key_debounce #(
  parameter int DEBOUNCE_TICKS = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic [1:0]    sync;
  logic          stable, stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync     <= {sync[0], key};
      stable_q <= stable;
      press    <= stable & ~stable_q;
      if (sync[1] == stable)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
        stable <= sync[1];
        cnt    <= '0;
      end else
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mole_judge.sv
// Gameplay engine: picks a mole from the LFSR, times gap and pop-up windows,
// judges debounced presses and keeps the saturating score for game_mem.
module mole_judge
  import mole_judge_pkg::*;
#(
  parameter int          MOLE_TICKS     = DEF_MOLE_TICKS,
  parameter int          GAP_TICKS      = DEF_GAP_TICKS,
  parameter int          DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_active,
  input  logic [3:0]         key_n,
  output logic               mole_up,
  output logic [1:0]         mole_idx,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic               score_we
);

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int TMAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(TMAX);

  logic [NUM_MOLES-1:0] press;
  logic [1:0]           state;
  logic [TW-1:0]        tick;
  logic [15:0]          lfsr;

  for (genvar g = 0; g < NUM_MOLES; g++) begin : g_key
    key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_key (
      .clk   (clk),
      .reset (reset),
      .key   (~key_n[g]),
      .press (press[g])
    );
  end

  assign mole_up = (state == ST_UP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      tick       <= '0;
      lfsr       <= SEED;
      mole_idx   <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score      <= '0;
      score_we   <= 1'b0;
    end else begin
      lfsr       <= lfsr_step(lfsr);
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score_we   <= 1'b0;
      // Leaving the game freezes the score so GameOver can show it
      if (!game_active)
        state <= ST_IDLE;
      else begin
        case (state)
          ST_IDLE: begin
            score    <= '0;
            score_we <= |score;
            tick     <= TW'(GAP_TICKS - 1);
            state    <= ST_GAP;
          end
          ST_GAP: begin
            if (tick == '0) begin
              mole_idx <= lfsr[1:0];
              tick     <= TW'(MOLE_TICKS - 1);
              state    <= ST_UP;
            end else
              tick <= tick - TW'(1);
          end
          ST_UP: begin
            // A press always beats a same-cycle window expiry
            if (|press) begin
              state <= ST_GAP;
              tick  <= TW'(GAP_TICKS - 1);
              if (press[mole_idx]) begin
                hit_pulse <= 1'b1;
                if (!(&score)) begin
                  score    <= score + SCORE_W'(1);
                  score_we <= 1'b1;
                end
              end else
                miss_pulse <= 1'b1;
            end else if (tick == '0) begin
              miss_pulse <= 1'b1;
              state      <= ST_GAP;
              tick       <= TW'(GAP_TICKS - 1);
            end else
              tick <= tick - TW'(1);
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
